// File: rtl/piso_pkg.sv
// Shared definitions for the 5-bit parallel-in, serial-out transmitter:
// state encoding, word width and the index of the final bit.
package piso_pkg;

    localparam int WORD_W = 5;
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage : piso_pkg

// File: rtl/piso5_tx_shift5.sv
// 5-bit register with parallel load taking priority over a zero-filling shift
// toward the send end, plus synchronous active-low clear.
module shift5
    import piso_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              sh,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] shifted;

    // Left shift moves bit 3 into the send position bit 4; right shift moves bit 1 into bit 0.
    assign shifted = MSB_FIRST ? {q[WORD_W-2:0], 1'b0} : {1'b0, q[WORD_W-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (sh) begin
            q <= shifted;
        end
    end

endmodule : shift5

// File: rtl/piso5_tx.sv
// Parallel-in, serial-out transmitter for 5-bit words: valid/ready word input,
// bit-serial output with valid/last framing and downstream back-pressure.
module piso5_tx
    import piso_pkg::*;
#(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              sout_last,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [WORD_W-1:0] sr;
    logic              ld;
    logic              sh;
    logic              shifting;
    logic              at_last;
    logic              cnt_ok;
    logic              in_hs;
    logic              beat;
    logic              send_bit;

    assign shifting = (state == ST_SHIFT);
    assign at_last  = (cnt == LAST_IDX);
    assign cnt_ok   = (cnt <= LAST_IDX);

    // Every output is forced inactive while reset is asserted, not only after the edge.
    assign in_ready   = rst & ((state == ST_IDLE) | (shifting & at_last & out_ready));
    assign sout_valid = rst & shifting;
    assign sout_last  = rst & shifting & at_last;
    assign busy       = rst & shifting;

    assign send_bit = MSB_FIRST ? sr[WORD_W-1] : sr[0];
    assign sout     = sout_valid ? send_bit : IDLE_LEVEL;

    assign in_hs = in_valid & in_ready;
    assign beat  = sout_valid & out_ready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld        = 1'b0;
        sh        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_hs) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = 3'd0;
                    ld        = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!cnt_ok) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 3'd0;
                end else if (in_hs) begin
                    // Only reachable on the last beat; the new word replaces the shift.
                    cnt_nxt = 3'd0;
                    ld      = 1'b1;
                end else if (beat) begin
                    sh = 1'b1;
                    if (at_last) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    shift5 #(
        .MSB_FIRST(MSB_FIRST)
    ) u_sr (
        .clk(clk),
        .rst(rst),
        .ld (ld),
        .sh (sh),
        .d  (in_data),
        .q  (sr)
    );

endmodule : piso5_tx

// File: doc/piso5_tx.md
# piso5_tx

Parallel-in, serial-out transmitter for 5-bit words. It is the read-side counterpart of the team's 5-bit enable-loaded register. It accepts a word over a valid/ready handshake, holds it, and shifts it out one bit per cycle with its own valid/last framing. Downstream back-pressure is supported. The block sits between the 5-bit datapath registers and any bit-serial consumer, such as a checker, a link or a serial comparator.

## Interface
Parameters:
- MSB_FIRST, default 1: 1 = bit 4 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, default 0: value driven on sout whenever sout_valid is 0.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-low. rst=0 at a rising edge resets the block.
- in_data  in  5  parallel word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- out_ready  in  1  consumer takes the current bit this cycle.
- sout  out  1  current serial bit.
- sout_valid  out  1  sout carries a data bit.
- sout_last  out  1  current bit is the final bit of the word.
- busy  out  1  a word is held (state SHIFT).

## Operation
Internal state:
- FSM with two states, IDLE and SHIFT.
- 5-bit shift register sr.
- 3-bit bit counter cnt, range 0..4.

Handshakes:
- An input handshake occurs when in_valid=1 and in_ready=1 at a rising edge. On that edge: sr <= in_data, cnt <= 0, state <= SHIFT.
- An output beat occurs when sout_valid=1 and out_ready=1 at a rising edge. On that edge:
  - sr shifts toward the send end: left if MSB_FIRST=1, right if MSB_FIRST=0. Zero fill.
  - cnt <= cnt+1.

Outputs (all combinational from registered state):
- in_ready = rst & (state==IDLE | (state==SHIFT & cnt==4 & out_ready)).
- sout_valid = (state==SHIFT).
- sout = sr[4] if MSB_FIRST, else sr[0]. Equals IDLE_LEVEL when sout_valid=0.
- sout_last = (state==SHIFT & cnt==4).
- busy = (state==SHIFT).

Transitions:
- IDLE -> SHIFT on an input handshake.
- SHIFT -> IDLE on the last output beat (cnt==4) with no simultaneous input handshake.
- SHIFT -> SHIFT (new word) on the last output beat with a simultaneous input handshake. The load takes priority over the shift: sr <= in_data, cnt <= 0.
- In SHIFT with cnt<4, in_valid is ignored. in_data has no effect.

Out-of-range cnt:
- cnt never exceeds 4.
- Any illegal state or cnt value (5..7) returns the block to IDLE on the next edge.

## Timing
Reset:
- rst=0 at an edge sets state=IDLE, sr=0, cnt=0.
- While rst=0: in_ready=0, sout_valid=0, sout_last=0, busy=0, sout=IDLE_LEVEL.
- Reset mid-word discards the word. No sout_last is issued for it.
- in_ready=1 in the first cycle after rst returns to 1.

Latency and throughput (out_ready held at 1):
- Handshake at edge k gives bit 0 of the word in cycle k+1.
- The final bit is presented in cycle k+5 with sout_last=1.
- A new word accepted at edge k+5 presents its first bit in cycle k+6. Sustained rate is 5 cycles/word with no gap.

Stall:
- out_ready=0 freezes sr, cnt, sout, sout_valid and sout_last.
- in_ready stays 0 during the stall, including on the last bit.

Other boundary conditions:
- From IDLE, in_valid=1 and out_ready=0 still loads. The first bit is then held until out_ready rises.

## Structure
- Shared package piso_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - WORD_W=5;
  - LAST_IDX=3'd4.
- One sub-module is natural: shift5, a 5-bit register with parallel load (ld) taking priority over shift (sh), direction parameter and synchronous active-low clear.
- The FSM and counter live in the top module.

## Test plan
- Reset then in_data=5'b10110 pulsed valid for one cycle, out_ready=1, MSB_FIRST=1 -> sout=1,0,1,1,0 in cycles 1..5. sout_last only in cycle 5. sout_valid=0 and sout=0 in cycle 6.
- Same word with MSB_FIRST=0 -> sout=0,1,1,0,1. sout_last on the fifth bit.
- Back-to-back: 5'b10110 then 5'b01011, with in_valid held -> second word accepted on the sout_last edge. Ten contiguous valid bits 1,0,1,1,0,0,1,0,1,1. Two sout_last pulses, five cycles apart.
- Stall: out_ready=0 for 3 cycles while bit index 2 is shown (value 1) -> sout, sout_valid and cnt unchanged for 3 cycles, and the remaining bits 1,0 follow. in_valid=1 with in_data=5'b11111 during the stall -> ignored, no corruption.
- Reset mid-word: rst=0 for one edge after bit index 1 of 5'b10110 -> next cycle sout_valid=0, busy=0, in_ready=0. After release, in_ready=1 and no sout_last appears for the aborted word.
- Load while stalled from IDLE: in_valid=1, in_data=5'b00001, out_ready=0 -> busy=1, sout=0 held. Release out_ready -> 0,0,0,0,1 with last on the 1.
